jx2_mem_line_bridge: RTL

//  Downstream of the core's 128-bit memory port (memAddr/memOpm/memOutData/memInData/memOK).

---
 rtl/jx2_mem_line_bridge_if.sv | 43 ++++
 rtl/jx2_mem_line_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jx2_mem_line_bridge_if.sv
// ---------------------------------------------------------------------------
// Interfaces for jx2_mem_line_bridge.
//
// jx2_mem_core_if : the core's 128-bit line port.
//   master = core   (drives memAddr, memOpm, memOutData; sees memInData, memOK)
//   slave  = bridge (sees the request; returns memInData and the memOK status)
//   memAddr    [31:0]  line address, bits [3:0] ignored by the bridge
//   memOpm     [4:0]   0 = idle, [4:3]=01 line read, [4:3]=10 line write
//   memOutData [127:0] write line, lane k = bits [32k+31:32k]
//   memInData  [127:0] read line returned to the core
//   memOK      [1:0]   READY=00, OK=01, HOLD=10, FAULT=11
//
// jx2_mem_ext_if : the 32-bit acked external bus.
//   master = bridge (drives extAddr, extDataOut, extRd, extWr)
//   slave  = memory (returns extDataIn, extAck)
//   extAddr    [31:0]  beat address
//   extDataOut [31:0]  write beat data
//   extDataIn  [31:0]  read beat data, valid with extAck
//   extRd/extWr        strobes, held high until extAck
//   extAck             single-cycle beat completion pulse
// ---------------------------------------------------------------------------
interface jx2_mem_core_if;
  logic [31:0]  memAddr;
  logic [4:0]   memOpm;
  logic [127:0] memOutData;
  logic [127:0] memInData;
  logic [1:0]   memOK;

  modport master (output memAddr, memOpm, memOutData, input memInData, memOK);
  modport slave  (input memAddr, memOpm, memOutData, output memInData, memOK);
endinterface

interface jx2_mem_ext_if;
  logic [31:0] extAddr;
  logic [31:0] extDataOut;
  logic [31:0] extDataIn;
  logic        extRd;
  logic        extWr;
  logic        extAck;

  modport master (output extAddr, extDataOut, extRd, extWr, input extDataIn, extAck);
  modport slave  (input extAddr, extDataOut, extRd, extWr, output extDataIn, extAck);
endinterface

// File: rtl/jx2_mem_line_bridge.sv
// ---------------------------------------------------------------------------
// jx2_mem_line_bridge
//
// Splits each 128-bit line read/write from the core into four 32-bit beats
// on a simple strobe/ack external bus, beats issued strictly 0..3. One
// request is in flight at a time; the core holds memOpm until it sees OK or
// FAULT and must return memOpm to 0 before the next request is accepted.
//
// Ports:
//   clock  in  core clock, all state on posedge
//   reset  in  asynchronous, active-high reset
//   core   jx2_mem_core_if.slave  : memAddr/memOpm/memOutData in,
//                                   memInData/memOK out
//   ext    jx2_mem_ext_if.master  : extAddr/extDataOut/extRd/extWr out,
//                                   extDataIn/extAck in
//
// Parameter:
//   TIMEOUT_CYC  strobe-high cycles without an ack before FAULT (timeout
//                build only)
//
// Build option:
//   JX2_MEMBRIDGE_TIMEOUT_EN  when defined, an 8-bit wait counter aborts a
//                             beat that is not acked within TIMEOUT_CYC
//                             cycles; when undefined the bridge waits
//                             indefinitely for extAck.
// ---------------------------------------------------------------------------
module jx2_mem_line_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clock,
  input  logic          reset,
  jx2_mem_core_if.slave core,
  jx2_mem_ext_if.master ext
);

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE,
    ST_FLT
  } state_t;

  state_t       state_q;
  logic [1:0]   beat_q;
  logic [27:0]  line_q;    // latched memAddr[31:4]
  logic [127:0] wline_q;   // latched write line
  logic [127:0] rline_q;   // assembled read line, drives memInData
  logic [1:0]   ok_q;
  logic [31:0]  addr_q;
  logic [31:0]  dout_q;
  logic         rd_q;
  logic         wr_q;
`ifdef JX2_MEMBRIDGE_TIMEOUT_EN
  logic [7:0]   wait_q;
`endif

  logic       opm_idle;
  logic       opm_rd;
  logic       opm_wr;
  logic       strobe;
  logic [1:0] beat_d;      // beat index presented after the current ack

  assign opm_idle = (core.memOpm == 5'd0);
  assign opm_rd   = (core.memOpm[4:3] == 2'b01);
  assign opm_wr   = (core.memOpm[4:3] == 2'b10);
  assign strobe   = rd_q | wr_q;
  assign beat_d   = beat_q + 2'd1;

  assign core.memInData = rline_q;
  assign core.memOK     = ok_q;
  assign ext.extAddr    = addr_q;
  assign ext.extDataOut = dout_q;
  assign ext.extRd      = rd_q;
  assign ext.extWr      = wr_q;

  // Line offset bits never reach the external bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^core.memAddr[3:0];
`ifndef JX2_MEMBRIDGE_TIMEOUT_EN
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // NOTE: the whole FSM and its outputs live in one clocked block; every
  // output is a flop, so no path exists for a latch to be inferred.
  // NOTE: the async reset clears every register, including the 128-bit
  // line buffers, because memInData has a defined reset value and strobes
  // must drop the instant reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      line_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      ok_q    <= OK_READY;
      addr_q  <= '0;
      dout_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef JX2_MEMBRIDGE_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of beat_q, rd_q and wr_q regardless of order.
      case (state_q)
        ST_IDLE: begin
          ok_q <= OK_READY;
          if (opm_rd || opm_wr) begin
            line_q  <= core.memAddr[31:4];
            wline_q <= core.memOutData;
            beat_q  <= 2'd0;
            addr_q  <= {core.memAddr[31:4], 4'b0000};
            dout_q  <= core.memOutData[31:0];
            rd_q    <= opm_rd;
            wr_q    <= opm_wr;
            ok_q    <= OK_HOLD;
            state_q <= opm_rd ? ST_RD : ST_WR;
`ifdef JX2_MEMBRIDGE_TIMEOUT_EN
            wait_q  <= '0;
`endif
          end else if (!opm_idle) begin
            ok_q    <= OK_FAULT;
            state_q <= ST_FLT;
          end
        end

        ST_RD, ST_WR: begin
          ok_q <= OK_HOLD;
          if (strobe && ext.extAck) begin
            if (state_q == ST_RD) begin
              rline_q[{beat_q, 5'd0} +: 32] <= ext.extDataIn;
            end
            // Strobe drops for one cycle while the next beat is set up.
            rd_q <= 1'b0;
            wr_q <= 1'b0;
`ifdef JX2_MEMBRIDGE_TIMEOUT_EN
            wait_q <= '0;
`endif
            if (beat_q == 2'd3) begin
              ok_q    <= OK_OK;
              state_q <= ST_DONE;
            end else begin
              beat_q <= beat_d;
              addr_q <= {line_q, beat_d, 2'b00};
              dout_q <= wline_q[{beat_d, 5'd0} +: 32];
            end
          end else if (!strobe) begin
            // Gap cycle: any ack here is ignored; raise the strobe.
            rd_q <= (state_q == ST_RD);
            wr_q <= (state_q == ST_WR);
`ifdef JX2_MEMBRIDGE_TIMEOUT_EN
            wait_q <= '0;
`endif
          end else begin
`ifdef JX2_MEMBRIDGE_TIMEOUT_EN
            // wait_q counts strobe-high cycles already spent without an ack.
            if (wait_q == 8'(TIMEOUT_CYC - 1)) begin
              rd_q    <= 1'b0;
              wr_q    <= 1'b0;
              ok_q    <= OK_FAULT;
              state_q <= ST_FLT;
            end else begin
              wait_q <= wait_q + 8'd1;
            end
`endif
          end
        end

        ST_DONE: begin
          ok_q <= OK_OK;
          if (opm_idle) begin
            ok_q    <= OK_READY;
            state_q <= ST_IDLE;
          end
        end

        ST_FLT: begin
          ok_q <= OK_FAULT;
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          if (opm_idle) begin
            ok_q    <= OK_READY;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          ok_q    <= OK_READY;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
